seq_detector_prog: RTL

Parametrised, runtime-programmable serial sequence detector with overlap mode, don't-care masking, input qualification and a saturating match counter. It sits on a one-bit serial data path, flags each occurrence of a configurable `SEQ_LEN`-bit pattern with a one-cycle registered pulse, and counts matches for status readout.

---
 rtl/seq_detector_prog.sv | 110 +++++++++++
 1 files changed

// File: rtl/seq_detector_prog.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_prog
//  Brief    : Runtime-programmable serial sequence detector with optional
//             overlap, per-bit don't-care mask, input qualification and a
//             saturating match counter. Emits a one-cycle registered pulse
//             for every occurrence of the loaded SEQ_LEN-bit pattern.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detector_prog #(
    parameter int                 SEQ_LEN     = 4,
    parameter logic [SEQ_LEN-1:0] DEFAULT_SEQ = SEQ_LEN'(4'b0101),
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [SEQ_LEN-1:0] cfg_seq,
    input  logic [SEQ_LEN-1:0] cfg_mask,
    input  logic               cnt_clr,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt
);

    // Fill counter must represent 0..SEQ_LEN inclusive.
    localparam int             FILL_W    = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

    logic [SEQ_LEN-1:0] r_pat;
    logic [SEQ_LEN-1:0] r_mask;
    logic [SEQ_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_dout;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sample;
    logic [SEQ_LEN-1:0] w_hist_next;
    logic [FILL_W-1:0]  w_fill_inc;
    logic               w_match;
    logic               w_cnt_sat;

    // Compare is done on the post-shift history so the pulse appears right
    // after the edge that captures the final pattern bit. A config load on
    // the same edge discards the data bit entirely.
    always_comb begin
        w_sample    = din_valid && !cfg_load;
        w_hist_next = {r_hist[SEQ_LEN-2:0], din};
        w_fill_inc  = (r_fill == FILL_FULL) ? FILL_FULL : (r_fill + FILL_W'(1));
        w_match     = w_sample && (w_fill_inc == FILL_FULL) &&
                      (((w_hist_next ^ r_pat) & r_mask) == '0);
        w_cnt_sat   = &r_cnt;
    end

    // Pattern/mask registers: reload on cfg_load, revert to default on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat  <= DEFAULT_SEQ;
            r_mask <= '1;
        end else if (cfg_load) begin
            r_pat  <= cfg_seq;
            r_mask <= cfg_mask;
        end
    end

    // History and fill tracking; fill gates the compare so stale history
    // after a load or a non-overlapping match never produces a false hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (cfg_load) begin
            r_fill <= '0;
        end else if (din_valid) begin
            r_hist <= w_hist_next;
            if (w_match && !overlap) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_inc;
            end
        end
    end

    // Registered match pulse, low whenever no valid sample completes a match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= 1'b0;
        end else begin
            r_dout <= w_match;
        end
    end

    // Saturating match counter; a clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && !w_cnt_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign dout      = r_dout;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire
